// File: rtl/pad_ctrl_pkg.sv
// pad_ctrl_pkg: shared types and constants for the APB pad controller.
//   pad_reg_t       - software-visible per-pad register contents
//   *_LSB / *_BIT   - bit positions of each field in the 32-bit APB word
//   SEL_SW          - sel value that routes the software sw_out/sw_oe to the pad
//   PAD_REG_STRIDE  - byte distance between consecutive pad registers
//   pad_word()      - packs a register plus its filtered input into a read word
package pad_ctrl_pkg;

   localparam int PAD_REG_STRIDE = 4;

   localparam int SEL_LSB    = 0;
   localparam int SEL_W      = 2;
   localparam int CFG_LSB    = 8;
   localparam int CFG_W      = 6;
   localparam int SW_OUT_BIT = 16;
   localparam int SW_OE_BIT  = 17;
   localparam int IN_BIT     = 24;

   localparam logic [SEL_W-1:0] SEL_SW = 2'd0;

   typedef struct packed {
      logic             sw_oe;
      logic             sw_out;
      logic [CFG_W-1:0] cfg;
      logic [SEL_W-1:0] sel;
   } pad_reg_t;

   function automatic logic [31:0] pad_word(input pad_reg_t r, input logic in_bit);
      logic [31:0] w;
      w                     = '0;
      w[SEL_LSB +: SEL_W]   = r.sel;
      w[CFG_LSB +: CFG_W]   = r.cfg;
      w[SW_OUT_BIT]         = r.sw_out;
      w[SW_OE_BIT]          = r.sw_oe;
      w[IN_BIT]             = in_bit;
      return w;
   endfunction

endpackage

// File: rtl/pad_in_filter.sv
// pad_in_filter: single-bit pad input conditioning.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   in_i          - raw asynchronous pad input
//   out_o         - synchronized (and, with PAD_CTRL_DEBOUNCE_EN, debounced) value
// Build option PAD_CTRL_DEBOUNCE_EN: when defined, the synchronized value must
// stay different from out_o for DEBOUNCE_CYCLES consecutive cycles before out_o
// follows it; otherwise out_o is the synchronizer output directly.
module pad_in_filter
   import pad_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic in_i,
   output logic out_o
);

   logic sync_q1;
   logic sync_q2;

   // NOTE: non-blocking assignments make sync_q2 take the previous sync_q1,
   // giving two real flop stages; blocking would collapse them into one.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= in_i;
         sync_q2 <= sync_q1;
      end
   end

`ifdef PAD_CTRL_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic             out_q;

   // The counter measures how long the synchronized value has disagreed with
   // the output; any agreement restarts the measurement, so short glitches die.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         out_q <= 1'b0;
      end else if (sync_q2 == out_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         out_q <= sync_q2;
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign out_o = out_q;
`else
   assign out_o = sync_q2;
`endif

endmodule

// File: rtl/pad_ctrl_apb.sv
// pad_ctrl_apb: APB-programmable pad controller.
//   APB slave  : paddr_i, pwdata_i, pwrite_i, psel_i, penable_i -> prdata_o,
//                pready_o (always 1), pslverr_o (index >= N_IO)
//   Peripherals: periph_out_i/periph_oe_i (functions 1..3), periph_in_o
//   Pad frame  : io_out_o, io_oe_o, pad_cfg_o driven; io_in_i received
// One register per pad at byte offset PAD_REG_STRIDE*i holding sel, cfg,
// sw_out, sw_oe; bit 24 reads back the filtered pad input.
// Build option PAD_CTRL_DEBOUNCE_EN enables the per-pad input debounce filter.
module pad_ctrl_apb
   import pad_ctrl_pkg::*;
#(
   parameter int N_IO            = 56,
   parameter int NBIT_PADCFG     = 6,
   parameter int APB_ADDR_WIDTH  = 12,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [APB_ADDR_WIDTH-1:0]           paddr_i,
   input  logic [31:0]                         pwdata_i,
   input  logic                                pwrite_i,
   input  logic                                psel_i,
   input  logic                                penable_i,
   output logic [31:0]                         prdata_o,
   output logic                                pready_o,
   output logic                                pslverr_o,
   input  logic [N_IO-1:0][2:0]                periph_out_i,
   input  logic [N_IO-1:0][2:0]                periph_oe_i,
   output logic [N_IO-1:0]                     periph_in_o,
   output logic [N_IO-1:0]                     io_out_o,
   output logic [N_IO-1:0]                     io_oe_o,
   output logic [N_IO-1:0][NBIT_PADCFG-1:0]    pad_cfg_o,
   input  logic [N_IO-1:0]                     io_in_i
);

   localparam int ADDR_LSB = $clog2(PAD_REG_STRIDE);
   localparam int AIDX_W   = APB_ADDR_WIDTH - ADDR_LSB;
   localparam int IDX_W    = $clog2(N_IO);
   localparam logic [AIDX_W-1:0] N_IO_IDX = AIDX_W'(N_IO);

   logic [AIDX_W-1:0] addr_idx;
   logic [IDX_W-1:0]  pad_idx;
   logic              in_range;
   logic              access;
   logic              wr_en;
   pad_reg_t          wr_reg;
   pad_reg_t          regs_q [N_IO];

   // Byte-lane bits of the address and reserved write-data bits carry no meaning.
   logic unused_bits;
   assign unused_bits = ^{paddr_i[ADDR_LSB-1:0], pwdata_i[31:18], pwdata_i[15:14],
                          pwdata_i[7:2]};

   assign addr_idx  = paddr_i[APB_ADDR_WIDTH-1:ADDR_LSB];
   assign pad_idx   = addr_idx[IDX_W-1:0];
   assign in_range  = addr_idx < N_IO_IDX;
   assign access    = psel_i & penable_i;
   assign wr_en     = access & pwrite_i & in_range;
   assign pready_o  = 1'b1;
   assign pslverr_o = access & ~in_range;

   assign wr_reg = '{sw_oe:  pwdata_i[SW_OE_BIT],
                     sw_out: pwdata_i[SW_OUT_BIT],
                     cfg:    pwdata_i[CFG_LSB +: CFG_W],
                     sel:    pwdata_i[SEL_LSB +: SEL_W]};

   // NOTE: the register array is reset explicitly because a reset pad must
   // come up undriven; do not drop the loop to save reset fan-out.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < N_IO; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         regs_q[pad_idx] <= wr_reg;
      end
   end

   // Output mux is purely combinational so a sel change shows up the cycle
   // after the write edge and peripheral data passes through with no delay.
   // NOTE: both outputs get a default before the case so no latch is inferred.
   always_comb begin
      io_out_o = '0;
      io_oe_o  = '0;
      for (int i = 0; i < N_IO; i++) begin
         case (regs_q[i].sel)
            SEL_SW: begin
               io_out_o[i] = regs_q[i].sw_out;
               io_oe_o[i]  = regs_q[i].sw_oe;
            end
            2'd1: begin
               io_out_o[i] = periph_out_i[i][0];
               io_oe_o[i]  = periph_oe_i[i][0];
            end
            2'd2: begin
               io_out_o[i] = periph_out_i[i][1];
               io_oe_o[i]  = periph_oe_i[i][1];
            end
            default: begin
               io_out_o[i] = periph_out_i[i][2];
               io_oe_o[i]  = periph_oe_i[i][2];
            end
         endcase
      end
   end

   always_comb begin
      prdata_o = '0;
      if (access && !pwrite_i && in_range) begin
         prdata_o = pad_word(regs_q[pad_idx], periph_in_o[pad_idx]);
      end
   end

   for (genvar g = 0; g < N_IO; g++) begin : g_pad
      assign pad_cfg_o[g] = NBIT_PADCFG'(regs_q[g].cfg);

      pad_in_filter #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_in_filter (
         .clk_i (clk_i),
         .rst_ni(rst_ni),
         .in_i  (io_in_i[g]),
         .out_o (periph_in_o[g])
      );
   end

endmodule

// File: tb/tb_pad_ctrl_apb.sv
// tb_pad_ctrl_apb: self-checking bench for pad_ctrl_apb. Directed scenarios
// followed by randomized APB/peripheral/pad-input traffic, all checked against
// a behavioural model (register image array plus a sampled input history).
module tb_pad_ctrl_apb;

   localparam int N_IO  = 56;
   localparam int NBCFG = 6;
   localparam int AW    = 12;
   localparam int DBC   = 4;
   localparam logic [31:0] REG_MASK = 32'h0003_3F03;

   logic                        clk_i = 1'b0;
   logic                        rst_ni;
   logic [AW-1:0]               paddr_i;
   logic [31:0]                 pwdata_i;
   logic                        pwrite_i, psel_i, penable_i;
   logic [31:0]                 prdata_o;
   logic                        pready_o, pslverr_o;
   logic [N_IO-1:0][2:0]        periph_out_i, periph_oe_i;
   logic [N_IO-1:0]             periph_in_o, io_out_o, io_oe_o, io_in_i;
   logic [N_IO-1:0][NBCFG-1:0]  pad_cfg_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   pad_ctrl_apb #(
      .N_IO(N_IO), .NBIT_PADCFG(NBCFG), .APB_ADDR_WIDTH(AW), .DEBOUNCE_CYCLES(DBC)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .paddr_i(paddr_i), .pwdata_i(pwdata_i),
      .pwrite_i(pwrite_i), .psel_i(psel_i), .penable_i(penable_i),
      .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
      .periph_out_i(periph_out_i), .periph_oe_i(periph_oe_i),
      .periph_in_o(periph_in_o), .io_out_o(io_out_o), .io_oe_o(io_oe_o),
      .pad_cfg_o(pad_cfg_o), .io_in_i(io_in_i)
   );

   // ---------------- reference model ----------------
   logic [31:0]     reg_mem [N_IO];
   logic [N_IO-1:0] hist [DBC+2];   // hist[0] = io_in sampled at the latest edge
   logic [N_IO-1:0] exp_in;

   // Filtered input after the next edge, computed from the history before it.
   // Without the filter the pad value is the sample taken one edge earlier;
   // with it, a bit flips once the last DBC values seen at the synchronizer
   // output all disagree with the current output.
   function automatic logic [N_IO-1:0] next_in(input logic [N_IO-1:0] cur);
      logic [N_IO-1:0] r;
`ifdef PAD_CTRL_DEBOUNCE_EN
      r = cur;
      for (int b = 0; b < N_IO; b++) begin
         logic flip;
         flip = 1'b1;
         for (int j = 1; j <= DBC; j++) if (hist[j][b] == cur[b]) flip = 1'b0;
         if (flip) r[b] = ~cur[b];
      end
`else
      r = hist[0];
`endif
      return r;
   endfunction

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int j = 0; j < DBC + 2; j++) hist[j] <= '0;
         exp_in <= '0;
      end else begin
         exp_in  <= next_in(exp_in);
         hist[0] <= io_in_i;
         for (int j = 1; j < DBC + 2; j++) hist[j] <= hist[j-1];
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [335:0] got, input logic [335:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic clear_model_regs();
      for (int i = 0; i < N_IO; i++) reg_mem[i] = '0;
   endtask

   task automatic check_pads(input string tag);
      logic [N_IO-1:0]            eo, ee;
      logic [N_IO-1:0][NBCFG-1:0] ec;
      for (int i = 0; i < N_IO; i++) begin
         int sel;
         sel = int'(reg_mem[i][1:0]);
         if (sel == 0) begin
            eo[i] = reg_mem[i][16];
            ee[i] = reg_mem[i][17];
         end else begin
            eo[i] = periph_out_i[i][sel-1];
            ee[i] = periph_oe_i[i][sel-1];
         end
         ec[i] = reg_mem[i][13:8];
      end
      check({tag, ".io_out"}, io_out_o, eo);
      check({tag, ".io_oe"}, io_oe_o, ee);
      check({tag, ".pad_cfg"}, pad_cfg_o, ec);
      check({tag, ".periph_in"}, periph_in_o, exp_in);
   endtask

   task automatic apb_write(input logic [AW-1:0] addr, input logic [31:0] data);
      int idx;
      idx       = int'(addr[AW-1:2]);
      paddr_i   = addr;
      pwdata_i  = data;
      pwrite_i  = 1'b1;
      psel_i    = 1'b1;
      penable_i = 1'b0;
      tick();
      penable_i = 1'b1;
      #1;
      check("wr.pslverr", pslverr_o, idx >= N_IO);
      check("wr.pready", pready_o, 1'b1);
      @(posedge clk_i);
      if (idx < N_IO) reg_mem[idx] = data & REG_MASK;
      #1;
      psel_i    = 1'b0;
      penable_i = 1'b0;
      pwrite_i  = 1'b0;
   endtask

   task automatic apb_read(input logic [AW-1:0] addr);
      int          idx;
      logic [31:0] exp;
      idx       = int'(addr[AW-1:2]);
      paddr_i   = addr;
      pwrite_i  = 1'b0;
      psel_i    = 1'b1;
      penable_i = 1'b0;
      tick();
      check("rd.setup_prdata", prdata_o, 32'h0);
      penable_i = 1'b1;
      #1;
      exp = (idx < N_IO) ? (reg_mem[idx] | (32'(exp_in[idx]) << 24)) : 32'h0;
      check("rd.prdata", prdata_o, exp);
      check("rd.pslverr", pslverr_o, idx >= N_IO);
      tick();
      psel_i    = 1'b0;
      penable_i = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_ni       = 1'b0;
      paddr_i      = '0;
      pwdata_i     = '0;
      pwrite_i     = 1'b0;
      psel_i       = 1'b0;
      penable_i    = 1'b0;
      periph_out_i = '0;
      periph_oe_i  = '0;
      io_in_i      = '0;
      clear_model_regs();
      tick(2);

      // Reset state
      check("rst.io_oe", io_oe_o, '0);
      check("rst.io_out", io_out_o, '0);
      check("rst.pad_cfg", pad_cfg_o, '0);
      check("rst.periph_in", periph_in_o, '0);
      check("rst.pslverr", pslverr_o, 1'b0);
      check("rst.prdata", prdata_o, 32'h0);
      rst_ni = 1'b1;
      tick();
      apb_read(12'h028);

      // Software drive of pad 10
      apb_write(12'h028, 32'h0003_0000);
      check("sw.oe10", io_oe_o[10], 1'b1);
      check("sw.out10", io_out_o[10], 1'b1);
      apb_read(12'h028);
      check_pads("sw");

      // Peripheral function 2 on pad 20: combinational pass-through
      apb_write(12'h050, 32'h0000_0002);
      periph_oe_i[20][1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         periph_out_i[20][1] = k[0];
         periph_out_i[20][0] = ~k[0];
         #1;
         check("mux.out20", io_out_o[20], k[0]);
         check("mux.oe20", io_oe_o[20], 1'b1);
      end
      check_pads("mux");

      // Out-of-range index 56
      apb_write(12'h0E0, 32'hFFFF_FFFF);
      check_pads("oor_wr");
      apb_read(12'h0E0);

      // Input path on pad 3
      io_in_i[3] = 1'b1;
`ifdef PAD_CTRL_DEBOUNCE_EN
      for (int k = 1; k <= 5; k++) begin
         tick();
         check("in3.before", periph_in_o[3], 1'b0);
      end
      tick();
      check("in3.at6", periph_in_o[3], 1'b1);
`else
      tick();
      check("in3.at1", periph_in_o[3], 1'b0);
      tick();
      check("in3.at2", periph_in_o[3], 1'b1);
`endif
      apb_read(12'h00C);
      check_pads("in3");

`ifdef PAD_CTRL_DEBOUNCE_EN
      // 3-cycle glitch on pad 5 is swallowed
      io_in_i[5] = 1'b1;
      tick(3);
      io_in_i[5] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("glitch5", periph_in_o[5], 1'b0);
      end
      // Held level rises 6 cycles after the edge
      io_in_i[5] = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         check("hold5.before", periph_in_o[5], 1'b0);
      end
      tick();
      check("hold5.at6", periph_in_o[5], 1'b1);
      io_in_i[5] = 1'b0;
      tick(8);
      check("hold5.fall", periph_in_o[5], 1'b0);
      // Reset in the middle of a count
      io_in_i[5] = 1'b1;
      tick(4);
      rst_ni = 1'b0;
      clear_model_regs();
      #2;
      io_in_i[5] = 1'b0;
      check("rstcnt.during", periph_in_o[5], 1'b0);
      tick();
      rst_ni = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("rstcnt.after", periph_in_o[5], 1'b0);
      end
      check_pads("rstcnt");
`endif

      // Reset in the access phase of a write: transfer is lost
      paddr_i   = 12'h01C;
      pwdata_i  = 32'h0003_3F01;
      pwrite_i  = 1'b1;
      psel_i    = 1'b1;
      penable_i = 1'b0;
      tick();
      penable_i = 1'b1;
      #2;
      rst_ni = 1'b0;
      clear_model_regs();
      #1;
      psel_i    = 1'b0;
      penable_i = 1'b0;
      pwrite_i  = 1'b0;
      check("rstxfer.pad_cfg", pad_cfg_o, '0);
      tick();
      rst_ni = 1'b1;
      tick();
      apb_read(12'h01C);
      apb_write(12'h01C, 32'h0001_0000);
      check("rstxfer.out7", io_out_o[7], 1'b1);
      check_pads("rstxfer");

      // Randomized traffic
      for (int it = 0; it < 300; it++) begin
         int op;
         op = $urandom_range(0, 9);
         if (op <= 3) begin
            logic [AW-1:0] a;
            a = {4'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            apb_write(a, $urandom);
         end else if (op <= 5) begin
            logic [AW-1:0] a;
            a = {4'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            apb_read(a);
         end else if (op <= 7) begin
            periph_out_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            periph_oe_i  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            #1;
         end else begin
            for (int k = 0; k < 4; k++) io_in_i[$urandom_range(0, N_IO-1)] ^= 1'b1;
            tick($urandom_range(1, 8));
         end
         check_pads("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
